// File: rtl/stream_arb_pkg.sv
// ============================================================================
// stream_arb_pkg - shared types and helpers for the stream round-robin arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width that stays legal (>= 1 bit) even for tiny requester counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_rr_arbiter_picker.sv
// ============================================================================
// rr_priority_picker - combinational first-set search starting at a pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  localparam int SW = IDW + 1;

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   window;
  logic [SW-1:0]        offset;
  logic [SW-1:0]        sum;
  logic                 found;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign doubled   = {req, req};
  assign window    = NUM_REQ'(doubled >> ptr);
  assign any_valid = |req;

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && window[i]) begin
        offset = SW'(i);
        found  = 1'b1;
      end
    end
    sum = {1'b0, ptr} + offset;
    if (sum >= SW'(NUM_REQ)) begin
      sum = sum - SW'(NUM_REQ);
    end
    winner = sum[IDW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// stream_rr_arbiter - packet-level round-robin arbiter with registered output;
// optional grant-revoke timeout enabled by defining STREAM_ARB_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [NUM_REQ*WIDTH-1:0]         i_req_data,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ-1:0]               i_req_last,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [WIDTH-1:0]                 o_out_data,
  output logic                             o_out_valid,
  output logic                             o_out_last,
  input  logic                             i_out_ready,
  output logic [clog2_min1(NUM_REQ)-1:0]   o_grant_id,
  output logic                             o_busy
`ifdef STREAM_ARB_TIMEOUT_EN
  ,output logic                            o_timeout
`endif
);

  localparam int IDW = clog2_min1(NUM_REQ);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   next_ptr;
  logic             any_valid;
  logic             load_ok;
  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             timeout_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req       (i_req_valid),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign load_ok   = !o_out_valid || i_out_ready;
  assign sel_valid = i_req_valid[o_grant_id];
  assign sel_last  = i_req_last[o_grant_id];
  assign sel_data  = i_req_data[int'(o_grant_id)*WIDTH +: WIDTH];
  assign accept    = (state == GRANT) && sel_valid && load_ok;
  assign next_ptr  = (o_grant_id == IDW'(NUM_REQ - 1)) ? '0 : o_grant_id + IDW'(1);
  assign o_busy    = (state == GRANT);

  always_comb begin
    o_req_ready = '0;
    if (state == GRANT && load_ok) begin
      o_req_ready[o_grant_id] = 1'b1;
    end
  end

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  // Fires on the edge that would complete TIMEOUT_CYCLES stalled grant cycles.
  assign timeout_hit = (state == GRANT) && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      idle_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_hit;
      if (state != GRANT || accept || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      o_grant_id  <= '0;
      o_out_data  <= '0;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            o_grant_id <= winner;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if ((accept && sel_last) || timeout_hit) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        o_out_valid <= 1'b1;
        o_out_data  <= sel_data;
        o_out_last  <= sel_last;
      end else if (timeout_hit && load_ok) begin
        // Terminate the abandoned packet downstream with an empty last beat.
        o_out_valid <= 1'b1;
        o_out_data  <= '0;
        o_out_last  <= 1'b1;
      end else if (load_ok) begin
        o_out_valid <= 1'b0;
        o_out_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// tb_stream_rr_arbiter - directed and randomized checks of stream_rr_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

  localparam int W  = 16;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef STREAM_ARB_TIMEOUT_EN
  logic            timeout;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] bdata [NR][$];
  bit           blast [NR][$];
  int           plen  [NR][$];
  logic [W-1:0] exp_d [$];
  bit           exp_l [$];

  stream_rr_arbiter #(
    .WIDTH          (W),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_out_last  (out_last),
    .i_out_ready (out_ready),
    .o_grant_id  (grant_id),
    .o_busy      (busy)
`ifdef STREAM_ARB_TIMEOUT_EN
    ,.o_timeout  (timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, want completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int viol = 0;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0)   begin bad++; $display("FAIL rst_last: got %b want 0", out_last); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (req_ready !== 4'b0)  begin bad++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    total++; if (grant_id !== 2'd0)   begin bad++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    total++; if (out_data !== 16'h0)  begin bad++; $display("FAIL rst_data: got %h want 0000", out_data); end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0) viol++;
    end
    total++; if (viol != 0) begin bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", viol); end
  endtask

  task automatic test_single_packet();
    logic [W-1:0] beats [3];
    logic [W-1:0] got_d [$];
    bit           got_l [$];
    int           got_c [$];
    int           idx = 0;
    beats[0] = 16'h0011; beats[1] = 16'h0022; beats[2] = 16'h0033;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      req_valid[2]      = (idx < 3);
      req_data[2*W +: W] = (idx < 3) ? beats[idx] : 16'h0;
      req_last[2]       = (idx == 2);
      #1;
      if (cyc == 1) begin
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL sp_ready: got %b want 0100", req_ready); end
        total++; if (grant_id !== 2'd2)     begin bad++; $display("FAIL sp_grant: got %0d want 2", grant_id); end
        total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL sp_bubble: got %b want 0", out_valid); end
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last); got_c.push_back(cyc);
      end
      if (req_valid[2] && req_ready[2]) idx++;
      @(negedge clk);
    end
    req_valid = '0;
    total++;
    if (got_d.size() != 3) begin
      bad++; $display("FAIL sp_count: got %0d beats want 3", got_d.size());
    end else begin
      total++; if (got_c[0] != 2) begin bad++; $display("FAIL sp_latency: got %0d want 2", got_c[0]); end
      for (int j = 0; j < 3; j++) begin
        total++; if (got_d[j] !== beats[j]) begin bad++; $display("FAIL sp_data%0d: got %h want %h", j, got_d[j], beats[j]); end
        total++; if (got_l[j] != (j == 2))  begin bad++; $display("FAIL sp_last%0d: got %b want %b", j, got_l[j], (j == 2)); end
      end
    end
  endtask

  task automatic test_round_robin();
    int           b [NR];
    logic [W-1:0] got_d [$];
    bit           got_l [$];
    int           got_c [$];
    logic [1:0]   got_g [$];
    do_reset();
    for (int r = 0; r < NR; r++) b[r] = 0;
    for (int cyc = 0; cyc < 60 && got_d.size() < 16; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        req_valid[r]       = 1'b1;
        req_data[r*W +: W] = {8'(r), 8'(b[r])};
        req_last[r]        = (b[r] == 1);
      end
      #1;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last);
        got_c.push_back(cyc); got_g.push_back(grant_id);
      end
      for (int r = 0; r < NR; r++) if (req_valid[r] && req_ready[r]) b[r] = 1 - b[r];
      @(negedge clk);
    end
    req_valid = '0;
    total++;
    if (got_d.size() != 16) begin
      bad++; $display("FAIL rr_count: got %0d beats want 16", got_d.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        int id   = (j / 2) % NR;
        int beat = j % 2;
        logic [W-1:0] e = {8'(id), 8'(beat)};
        total++; if (got_d[j] !== e)        begin bad++; $display("FAIL rr_data%0d: got %h want %h", j, got_d[j], e); end
        total++; if (got_g[j] !== 2'(id))   begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", j, got_g[j], id); end
        total++; if (got_l[j] != (beat == 1)) begin bad++; $display("FAIL rr_last%0d: got %b want %b", j, got_l[j], beat == 1); end
        if (j > 0) begin
          int gap = (beat == 0) ? 2 : 1;
          total++; if (got_c[j] - got_c[j-1] != gap) begin bad++; $display("FAIL rr_gap%0d: got %0d want %0d", j, got_c[j] - got_c[j-1], gap); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]   pat = 4'b1001;
    logic [W-1:0] got_d [$];
    bit           got_l [$];
    logic [W-1:0] held_d = '0;
    bit           held = 1'b0;
    bit           started = 1'b0;
    int           idx = 0;
    int           n = 0;
    do_reset();
    for (int cyc = 0; cyc < 40 && got_d.size() < 5; cyc++) begin
      req_valid[1]   = (idx < 5);
      req_data[W +: W] = 16'h1000 + 16'(idx);
      req_last[1]    = (idx == 4);
      started = started || out_valid;
      if (started) begin out_ready = pat[n % 4]; n++; end
      else out_ready = 1'b1;
      #1;
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_d) begin
          bad++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held_d);
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin got_d.push_back(out_data); got_l.push_back(out_last); end
      if (req_valid[1] && req_ready[1]) idx++;
      @(negedge clk);
    end
    req_valid = '0; out_ready = 1'b1;
    total++;
    if (got_d.size() != 5) begin
      bad++; $display("FAIL bp_count: got %0d beats want 5", got_d.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        total++; if (got_d[j] !== 16'h1000 + 16'(j)) begin bad++; $display("FAIL bp_data%0d: got %h want %h", j, got_d[j], 16'h1000 + 16'(j)); end
        total++; if (got_l[j] != (j == 4)) begin bad++; $display("FAIL bp_last%0d: got %b want %b", j, got_l[j], j == 4); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    do_reset();
    for (int cyc = 0; cyc < 10 && idx < 1; cyc++) begin
      req_valid[1] = 1'b1; req_data[W +: W] = 16'h4400 + 16'(idx); req_last[1] = 1'b0;
      #1;
      if (req_valid[1] && req_ready[1]) idx++;
      @(negedge clk);
    end
    total++; if (idx != 1) begin bad++; $display("FAIL rm_first: got %0d beats want 1", idx); end
    rst = 1'b1;
    req_data[W +: W] = 16'h4401;
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL rm_last: got %b want 0", out_last); end
    rst = 1'b0;
    req_valid = 4'b1000; req_data[3*W +: W] = 16'h3333; req_last = 4'b1000;
    @(negedge clk); #1;
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL rm_grant: got %0d want 3", grant_id); end
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL rm_busy2: got %b want 1", busy); end
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_last !== 1'b1) begin
      bad++; $display("FAIL rm_beat: got v=%b d=%h l=%b want v=1 d=3333 l=1", out_valid, out_data, out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int pos [NR];
    bit in_pkt [NR];
    int pk [NR];
    int rd [NR];
    int ptr, cyc, npk, len, k, extra;
    bit found;
    do_reset();
    for (int r = 0; r < NR; r++) begin
      bdata[r].delete(); blast[r].delete(); plen[r].delete();
      npk = $urandom_range(1, 4);
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 5);
        plen[r].push_back(len);
        for (int b = 0; b < len; b++) begin
          bdata[r].push_back(W'($urandom));
          blast[r].push_back(b == len - 1);
        end
      end
      pos[r] = 0; in_pkt[r] = 1'b0; pk[r] = 0; rd[r] = 0;
    end
    // Every waiting requester offers its packet, so the order is fixed by the rr rule alone.
    exp_d.delete(); exp_l.delete();
    ptr = 0; k = 0;
    do begin
      found = 1'b0;
      for (int off = 0; off < NR && !found; off++) begin
        k = (ptr + off) % NR;
        if (pk[k] < plen[k].size()) found = 1'b1;
      end
      if (found) begin
        for (int b = 0; b < plen[k][pk[k]]; b++) begin
          exp_d.push_back(bdata[k][rd[k]]); exp_l.push_back(blast[k][rd[k]]); rd[k]++;
        end
        pk[k]++;
        ptr = (k + 1) % NR;
      end
    end while (found);

    cyc = 0;
    while (exp_d.size() > 0 && cyc < 4000) begin
      for (int r = 0; r < NR; r++) begin
        if (pos[r] < bdata[r].size()) begin
          req_valid[r]       = !in_pkt[r] || ($urandom_range(0, 3) != 0);
          req_data[r*W +: W] = bdata[r][pos[r]];
          req_last[r]        = blast[r][pos[r]];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++; if ($countones(req_ready) > 1) begin bad++; $display("FAIL rnd_onehot: got %b want one-hot or zero", req_ready); end
      if (out_valid && out_ready) begin
        total++; if (out_data !== exp_d[0]) begin bad++; $display("FAIL rnd_data: got %h want %h", out_data, exp_d[0]); end
        total++; if (out_last !== exp_l[0]) begin bad++; $display("FAIL rnd_last: got %b want %b", out_last, exp_l[0]); end
        void'(exp_d.pop_front()); void'(exp_l.pop_front());
      end
      for (int r = 0; r < NR; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          in_pkt[r] = !blast[r][pos[r]];
          pos[r]++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (exp_d.size() != 0) begin bad++; $display("FAIL rnd_done: got %0d beats left want 0", exp_d.size()); end
    req_valid = '0; req_last = '0; out_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) extra++;
      @(negedge clk);
    end
    total++; if (extra != 0) begin bad++; $display("FAIL rnd_extra: got %0d extra beats want 0", extra); end
  endtask

`ifdef STREAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [W-1:0] got_d [$];
    bit           got_l [$];
    logic [1:0]   got_g [$];
    int c_acc = -1, t_cyc = -1, pulses = 0;
    bit a_done = 1'b0, b_done = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      req_valid[0] = !a_done; req_data[0 +: W] = 16'hAAAA; req_last[0] = 1'b0;
      req_valid[1] = !b_done; req_data[W +: W] = 16'hBBBB; req_last[1] = 1'b1;
      #1;
      if (timeout) begin pulses++; if (t_cyc < 0) t_cyc = cyc; end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last); got_g.push_back(grant_id);
      end
      if (req_valid[0] && req_ready[0]) begin a_done = 1'b1; c_acc = cyc; end
      if (req_valid[1] && req_ready[1]) b_done = 1'b1;
      @(negedge clk);
    end
    req_valid = '0; req_last = '0;
    total++; if (pulses != 1)        begin bad++; $display("FAIL to_pulse: got %0d pulses want 1", pulses); end
    total++; if (t_cyc - c_acc != 9) begin bad++; $display("FAIL to_delay: got %0d want 9", t_cyc - c_acc); end
    total++;
    if (got_d.size() != 3) begin
      bad++; $display("FAIL to_count: got %0d beats want 3", got_d.size());
    end else begin
      total++; if (got_d[0] !== 16'hAAAA || got_l[0] !== 1'b0) begin bad++; $display("FAIL to_b0: got %h/%b want aaaa/0", got_d[0], got_l[0]); end
      total++; if (got_d[1] !== 16'h0000 || got_l[1] !== 1'b1) begin bad++; $display("FAIL to_b1: got %h/%b want 0000/1", got_d[1], got_l[1]); end
      total++; if (got_d[2] !== 16'hBBBB || got_l[2] !== 1'b1) begin bad++; $display("FAIL to_b2: got %h/%b want bbbb/1", got_d[2], got_l[2]); end
      total++; if (got_g[2] !== 2'd1) begin bad++; $display("FAIL to_grant: got %0d want 1", got_g[2]); end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    for (int i = 0; i < 4; i++) test_random();
`ifdef STREAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one valid/data streaming datapath (WIDTH-bit in/out, single-cycle valid) among NUM_REQ packet requesters.
- Round-robin arbitration at packet granularity. A grant is held from the first beat through the beat carrying last.
- A registered output stage drives the shared datapath's i_in_data/i_in_valid, with optional downstream backpressure.
- Sits directly upstream of the shared processing module.

Parameters:
- WIDTH, 16, data bits per beat.
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT_CYCLES, 64, idle-stall limit while granted (used only with the optional feature).

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_req_data  in  NUM_REQ*WIDTH  requester data; requester k occupies bits [k*WIDTH +: WIDTH].
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid.
- o_req_ready  out  NUM_REQ  per-requester beat accept; one-hot or zero.
- o_out_data  out  WIDTH  beat to shared datapath.
- o_out_valid  out  1  beat valid to shared datapath.
- o_out_last  out  1  end-of-packet flag on output.
- i_out_ready  in  1  downstream accept; tie to 1 for a datapath without backpressure.
- o_grant_id  out  $clog2(NUM_REQ)  index of current or most recent grant.
- o_busy  out  1  high while in GRANT state.

Behaviour:
- Reset: synchronous, active-high, on i_clock.
  - State returns to IDLE; rr pointer returns to 0.
  - o_out_valid, o_out_last, o_busy, o_req_ready and o_grant_id all go to 0; o_out_data goes to 0.
  - Reset mid-packet truncates the packet: no last is emitted.
- FSM states: IDLE, GRANT.
- IDLE:
  - o_req_ready is all 0.
  - If any i_req_valid is set, pick the first valid index searching upward from the rr pointer, wrapping at NUM_REQ.
  - Register that index as o_grant_id and move to GRANT on the next edge.
  - Arbitration costs exactly one bubble cycle per packet.
- GRANT:
  - o_req_ready[g] = !o_out_valid || i_out_ready. All other ready bits are 0.
  - Beat accepted when i_req_valid[g] && o_req_ready[g]. Data and last are registered into the output stage on the same edge.
  - Accepted beat with last: next state is IDLE, and the rr pointer becomes (g+1) mod NUM_REQ.
  - Valid may drop mid-packet. The grant holds indefinitely unless STREAM_ARB_TIMEOUT_EN is defined.
- Output register:
  - Loads when !o_out_valid || i_out_ready.
  - o_out_valid stays asserted, with data held stable, while i_out_ready is 0.
  - Clears o_out_valid when drained and no new beat is accepted.
- Latency: request valid at cycle N (IDLE) -> ready at N+1 -> o_out_valid at N+2.
- Throughput: 1 beat/cycle within a packet when i_out_ready=1.
- Simultaneous requests: only the rr winner is served. The others keep valid asserted and wait; no beat is ever dropped or duplicated.
- A single-beat packet (valid and last on the first beat) returns to IDLE after one accept.
- Pointer wrap: a winner at NUM_REQ-1 sets the pointer to 0.
- Requester valid changes while in IDLE during the decision cycle: the registered decision uses that cycle's values only.

Optional Feature:
- Macro: STREAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments every GRANT cycle with no accepted beat and resets on each accept.
  - When it reaches TIMEOUT_CYCLES, the grant is revoked: state goes to IDLE and the pointer goes to g+1.
  - A one-cycle o_timeout pulse is emitted (extra 1-bit output port, reset 0).
  - If the output register is empty, or is loaded on that same edge, a zero-data beat with o_out_last=1 is injected to terminate the packet downstream.
- Undefined: no counter, no o_timeout port, grant held until last.

Decomposition:
- Package stream_arb_pkg:
  - state_t enum {IDLE, GRANT}.
  - Function clog2_min1(n), returning at least 1 bit for the id width.
- Sub-module rr_priority_picker: purely combinational.
  - Inputs: NUM_REQ-bit request vector and pointer.
  - Outputs: winner index and any-valid.
  - Implemented as a doubled-vector find-first-set.

Test Plan:
- Reset, no requests for 100 cycles -> o_out_valid never 1, o_busy 0, o_req_ready 0.
- Requester 2 sends a 3-beat packet 0x0011, 0x0022, 0x0033(last) -> output beats appear in that order starting 2 cycles after the first valid; o_grant_id=2; last on the third beat only.
- All 4 requesters continuously offer 2-beat packets with data = {id, beat} -> grant order 0,1,2,3,0,…; no interleaving within a packet; one bubble between packets.
- i_out_ready toggles 1,0,0,1 during a 5-beat packet from requester 1 -> o_out_data held stable while ready is 0; all 5 beats delivered exactly once, in order.
- i_reset asserted on the 2nd beat of a 4-beat packet -> next cycle o_out_valid=0 and o_busy=0; after release, requester 3 alone is granted first, since the pointer was reset to 0 and requesters 0-2 are idle.
- STREAM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: requester 0 sends 1 beat without last then stalls -> after 8 idle cycles o_timeout pulses, a last beat with 0x0000 is emitted, and a pending requester 1 is granted next.
